lfsr5_checker: RTL and testbench

Receive-side checker for the 5-bit LFSR pattern source. It consumes a stream of 5-bit words, self-synchronises to the LFSR sequence and then predicts each following word. While locked, it counts mismatches and declares loss of lock after repeated consecutive misses. It sits at the far end of any link or datapath driven by the LFSR generator, as a built-in pattern checker.

---
 rtl/lfsr5_pkg.sv | 24 ++
 rtl/lfsr5_checker.sv | 119 +++++++++++
 tb/tb_lfsr5_checker.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/lfsr5_pkg.sv
// Shared definitions for the 5-bit LFSR pattern generator and its receive-side checker.
// Both ends call lfsr5_next so the sequence is defined in exactly one place.
package lfsr5_pkg;

   localparam logic [4:0] LFSR5_SEED = 5'h1f;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } lfsr5_state_e;

   // Upper bits feed the lower ones, so later terms reuse n4/n2/n3.
   function automatic logic [4:0] lfsr5_next(input logic [4:0] d);
      logic n4, n3, n2, n1, n0;
      n4 = d[4] ^ d[1];
      n3 = d[3] ^ d[0];
      n2 = d[2] ^ n4;
      n1 = d[1] ^ n3;
      n0 = d[0] ^ n2;
      return {n4, n3, n2, n1, n0};
   endfunction

endpackage

// File: rtl/lfsr5_checker.sv
// Receive-side LFSR pattern checker: seeds from the stream, verifies, then free-runs and counts misses.
// Handshake: in_valid qualifies in_data for one cycle; there is no ready, so every valid word is consumed.
module lfsr5_checker
   import lfsr5_pkg::*;
#(
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 3,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             in_valid,
   input  logic [4:0]       in_data,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output lfsr5_state_e     state_dbg
);

   localparam int RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
   localparam int RUN_W   = $clog2(RUN_MAX + 1);
   localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_CNT);
   localparam logic [RUN_W-1:0] LOSS_RUN = RUN_W'(LOSS_CNT);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   lfsr5_state_e     state, state_nxt;
   logic [4:0]       pred, pred_nxt;
   logic [RUN_W-1:0] run, run_nxt, run_inc;
   logic [CNT_W-1:0] cnt_nxt;
   logic             err_now;

   always_comb begin
      state_nxt = state;
      pred_nxt  = pred;
      run_nxt   = run;
      err_now   = 1'b0;
      run_inc   = run + 1'b1;
      if (in_valid) begin
         case (state)
            SEARCH: begin
               if (in_data != 5'd0) begin
                  pred_nxt  = lfsr5_next(in_data);
                  run_nxt   = '0;
                  state_nxt = VERIFY;
               end
            end
            VERIFY: begin
               if (in_data == pred) begin
                  pred_nxt = lfsr5_next(in_data);
                  if (run_inc == LOCK_RUN) begin
                     state_nxt = LOCKED;
                     run_nxt   = '0;
                  end else begin
                     run_nxt = run_inc;
                  end
               end else if (in_data != 5'd0) begin
                  pred_nxt = lfsr5_next(in_data);
                  run_nxt  = '0;
               end else begin
                  state_nxt = SEARCH;
                  run_nxt   = '0;
               end
            end
            LOCKED: begin
               // Free-running: a corrupted word must never become the new seed.
               pred_nxt = lfsr5_next(pred);
               if (in_data == pred) begin
                  run_nxt = '0;
               end else begin
                  err_now = 1'b1;
                  if (run_inc == LOSS_RUN) begin
                     state_nxt = SEARCH;
                     run_nxt   = '0;
                  end else begin
                     run_nxt = run_inc;
                  end
               end
            end
            default: begin
               state_nxt = SEARCH;
               run_nxt   = '0;
            end
         endcase
      end
   end

   // Clear wins over the old value, then a same-cycle error counts on top of it.
   always_comb begin
      cnt_nxt = err_count;
      if (clr_cnt && err_now)
         cnt_nxt = CNT_W'(1);
      else if (clr_cnt)
         cnt_nxt = '0;
      else if (err_now && (err_count != CNT_MAX))
         cnt_nxt = err_count + 1'b1;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state     <= SEARCH;
         pred      <= LFSR5_SEED;
         run       <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_count <= '0;
      end else begin
         state     <= state_nxt;
         pred      <= pred_nxt;
         run       <= run_nxt;
         locked    <= (state_nxt == LOCKED);
         err_pulse <= err_now;
         err_count <= cnt_nxt;
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_lfsr5_checker.sv
// Directed bench for lfsr5_checker (LOCK_CNT=4, LOSS_CNT=3, CNT_W=2).
// Hand-derived sequence from seed 1f: 1f 06 12 02 17 0c 0f 13 09 01 0b 16.
module tb_lfsr5_checker;
   import lfsr5_pkg::*;

   logic         clk = 1'b0;
   logic         nreset = 1'b0;
   logic         in_valid = 1'b0;
   logic [4:0]   in_data = 5'd0;
   logic         clr_cnt = 1'b0;
   logic         locked;
   logic         err_pulse;
   logic [1:0]   err_count;
   lfsr5_state_e state_dbg;

   int n_checks = 0;
   int n_errors = 0;
   logic [4:0] exp_word;
   logic [4:0] acq_tbl [0:4] = '{5'h1f, 5'h06, 5'h12, 5'h02, 5'h17};

   lfsr5_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(2)) dut (
      .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_data(in_data),
      .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse),
      .err_count(err_count), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   // Reference next-word equations, written independently from the design.
   function automatic logic [4:0] ref_next(input logic [4:0] d);
      logic [4:0] n;
      n[4] = d[4] ^ d[1];
      n[3] = d[3] ^ d[0];
      n[2] = d[2] ^ n[4];
      n[1] = d[1] ^ n[3];
      n[0] = d[0] ^ n[2];
      return n;
   endfunction

   // Drive one cycle from the falling edge; outputs are sampled 1 time unit after the rising edge.
   task automatic drive(input logic v, input logic [4:0] w, input logic clr);
      @(negedge clk);
      in_valid = v;
      in_data  = w;
      clr_cnt  = clr;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clr_cnt  = 1'b0;
   endtask

   task automatic test_reset;
      n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL reset_locked got %0b want 0", locked); end
      n_checks++; if (err_pulse !== 1'b0) begin n_errors++; $display("FAIL reset_pulse got %0b want 0", err_pulse); end
      n_checks++; if (err_count !== 2'd0) begin n_errors++; $display("FAIL reset_count got %0d want 0", err_count); end
   endtask

   task automatic test_acquire;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, acq_tbl[i], 1'b0);
         n_checks++;
         if (locked !== (i == 4)) begin
            n_errors++; $display("FAIL acquire_locked word %0d got %0b want %0b", i, locked, (i == 4));
         end
      end
      n_checks++; if (err_count !== 2'd0) begin n_errors++; $display("FAIL acquire_count got %0d want 0", err_count); end
      exp_word = 5'h0c;
   endtask

   task automatic test_single_error;
      drive(1'b1, 5'h00, 1'b0);
      n_checks++; if (err_pulse !== 1'b1) begin n_errors++; $display("FAIL single_pulse got %0b want 1", err_pulse); end
      n_checks++; if (err_count !== 2'd1) begin n_errors++; $display("FAIL single_count got %0d want 1", err_count); end
      n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL single_locked got %0b want 1", locked); end
      drive(1'b1, 5'h0f, 1'b0);
      n_checks++; if (err_pulse !== 1'b0) begin n_errors++; $display("FAIL single_after_pulse got %0b want 0", err_pulse); end
      drive(1'b1, 5'h13, 1'b0);
      n_checks++; if (err_count !== 2'd1) begin n_errors++; $display("FAIL single_after_count got %0d want 1", err_count); end
      n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL single_after_locked got %0b want 1", locked); end
   endtask

   task automatic test_loss;
      drive(1'b0, 5'h00, 1'b1);
      n_checks++; if (err_count !== 2'd0) begin n_errors++; $display("FAIL loss_clear got %0d want 0", err_count); end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 5'h00, 1'b0);
         n_checks++;
         if (err_pulse !== 1'b1 || err_count !== 2'(i + 1) || locked !== (i < 2)) begin
            n_errors++;
            $display("FAIL loss_step %0d got pulse=%0b count=%0d locked=%0b want pulse=1 count=%0d locked=%0b",
                     i, err_pulse, err_count, locked, i + 1, (i < 2));
         end
      end
      drive(1'b0, 5'h00, 1'b0);
      n_checks++; if (err_pulse !== 1'b0 || locked !== 1'b0) begin
         n_errors++; $display("FAIL loss_idle got pulse=%0b locked=%0b want 0 0", err_pulse, locked);
      end
   endtask

   task automatic test_zero_idle;
      drive(1'b0, 5'h00, 1'b1);
      for (int i = 0; i < 4; i++) drive(1'b1, 5'h00, 1'b0);
      n_checks++; if (locked !== 1'b0 || err_count !== 2'd0) begin
         n_errors++; $display("FAIL zero_search got locked=%0b count=%0d want 0 0", locked, err_count);
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, acq_tbl[i], 1'b0);
         if (i < 4) begin
            drive(1'b0, 5'h1f, 1'b0);
            drive(1'b0, 5'h00, 1'b0);
         end
         if (i == 3) begin
            n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL idle_early_lock got %0b want 0", locked); end
         end
      end
      n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL idle_lock got %0b want 1", locked); end
      exp_word = 5'h0c;
   endtask

   task automatic test_saturation;
      drive(1'b0, 5'h00, 1'b1);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, exp_word ^ 5'h01, 1'b0);
         exp_word = ref_next(exp_word);
         n_checks++;
         if (err_count !== ((i < 3) ? 2'(i + 1) : 2'd3) || err_pulse !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_step %0d got count=%0d pulse=%0b want count=%0d pulse=1",
                     i, err_count, err_pulse, (i < 3) ? i + 1 : 3);
         end
         drive(1'b1, exp_word, 1'b0);
         exp_word = ref_next(exp_word);
      end
      n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL sat_locked got %0b want 1", locked); end
      drive(1'b1, exp_word ^ 5'h10, 1'b1);
      exp_word = ref_next(exp_word);
      n_checks++; if (err_count !== 2'd1 || err_pulse !== 1'b1) begin
         n_errors++; $display("FAIL clr_with_error got count=%0d pulse=%0b want 1 1", err_count, err_pulse);
      end
   endtask

   task automatic test_reset_mid;
      drive(1'b1, exp_word, 1'b0);
      exp_word = ref_next(exp_word);
      drive(1'b1, exp_word ^ 5'h04, 1'b0);
      exp_word = ref_next(exp_word);
      n_checks++; if (err_count !== 2'd2 || locked !== 1'b1) begin
         n_errors++; $display("FAIL pre_reset got count=%0d locked=%0b want 2 1", err_count, locked);
      end
      #2;
      nreset = 1'b0;
      #1;
      n_checks++; if (locked !== 1'b0 || err_count !== 2'd0 || err_pulse !== 1'b0) begin
         n_errors++; $display("FAIL async_reset got locked=%0b count=%0d pulse=%0b want 0 0 0", locked, err_count, err_pulse);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      nreset = 1'b1;
      for (int i = 0; i < 5; i++) drive(1'b1, acq_tbl[i], 1'b0);
      n_checks++; if (locked !== 1'b1 || err_count !== 2'd0) begin
         n_errors++; $display("FAIL relock got locked=%0b count=%0d want 1 0", locked, err_count);
      end
   endtask

   initial begin
      nreset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset;
      @(negedge clk);
      nreset = 1'b1;
      test_acquire;
      test_single_error;
      test_loss;
      test_zero_idle;
      test_saturation;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
